// File: rtl/vga_pkg.sv
// Shared mode defaults and sizing helpers for the raster timing generator.
// The default set is 640x480@60 with a two-clock pixel.
package vga_pkg;

  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_LOOKAHEAD = 4;

  function automatic int span_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Counter width for a modulus; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_timing_gen_raster_counter.sv
// Horizontal/vertical position pair advancing one pixel per step.
// Exposes only the next-state values so callers can register outputs in lockstep.
module raster_counter #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int HW      = 10,
  parameter int VW      = 10,
  parameter int H_RST   = 0,
  parameter int V_RST   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  output logic [HW-1:0] h_nxt,
  output logic [VW-1:0] v_nxt
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] h;
  logic [VW-1:0] v;

  always_comb begin
    h_nxt = h;
    v_nxt = v;
    if (step) begin
      if (h == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h_nxt = h + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= HW'(H_RST);
      v <= VW'(V_RST);
    end else begin
      h <= h_nxt;
      v <= v_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel strobe, syncs, DE, coordinates and a
// look-ahead fetch coordinate stream that leads display in scan order.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int LOOKAHEAD = DEF_LOOKAHEAD,
  localparam int H_TOTAL  = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL  = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int XW       = cnt_w(H_TOTAL),
  localparam int YW       = cnt_w(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_en,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic          blank,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          fetch_valid,
  output logic [XW-1:0] fetch_x,
  output logic [YW-1:0] fetch_y
);

  localparam int DW = cnt_w(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  // Inclusive bounds keep every constant inside the counter width.
  localparam logic [XW-1:0] H_ACT_LAST = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] HS_FIRST   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_LAST    = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] V_ACT_LAST = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] VS_FIRST   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_LAST    = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div;
  logic [XW-1:0] dh_n, fh_n;
  logic [YW-1:0] dv_n, fv_n;
  logic          de_n, hs_act, vs_act, fv_ok;

  assign pix_en = en && (div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     div <= '0;
    else if (en) div <= pix_en ? '0 : div + 1'b1;
  end

  raster_counter #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .HW(XW), .VW(YW),
    .H_RST(H_TOTAL - 1), .V_RST(V_TOTAL - 1)
  ) u_disp (
    .clk(clk), .rst(rst), .step(pix_en), .h_nxt(dh_n), .v_nxt(dv_n)
  );

  // Fetch starts LOOKAHEAD pixels ahead of the display's pre-roll position.
  raster_counter #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .HW(XW), .VW(YW),
    .H_RST(LOOKAHEAD - 1), .V_RST(0)
  ) u_fetch (
    .clk(clk), .rst(rst), .step(pix_en), .h_nxt(fh_n), .v_nxt(fv_n)
  );

  always_comb begin
    de_n   = (dh_n <= H_ACT_LAST) && (dv_n <= V_ACT_LAST);
    hs_act = (dh_n >= HS_FIRST) && (dh_n <= HS_LAST);
    vs_act = (dv_n >= VS_FIRST) && (dv_n <= VS_LAST);
    fv_ok  = (fh_n <= H_ACT_LAST) && (fv_n <= V_ACT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_x     <= '0;
      fetch_y     <= '0;
    end else begin
      line_start  <= pix_en && (dh_n == '0);
      frame_start <= pix_en && (dh_n == '0) && (dv_n == '0);
      if (pix_en) begin
        hs          <= hs_act ? HS_POL : ~HS_POL;
        vs          <= vs_act ? VS_POL : ~VS_POL;
        de          <= de_n;
        x           <= de_n ? dh_n : '0;
        y           <= de_n ? dv_n : '0;
        fetch_valid <= fv_ok;
        fetch_x     <= fv_ok ? fh_n : '0;
        fetch_y     <= fv_ok ? fv_n : '0;
      end
    end
  end

  assign blank = ~de;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 14x8 mode: main (CLK_DIV=2),
// HS_POL=1 variant and CLK_DIV=1 variant share clk/rst/en.
module tb_vga_timing_gen;

  localparam int HA = 8, VA = 4, LA = 3;
  localparam int HT = 14, FR = 112;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0;

  logic pix_en, hs, vs, de, blank, line_start, frame_start, fetch_valid;
  logic [3:0] x, fetch_x;
  logic [2:0] y, fetch_y;
  logic p_pix_en, p_hs, p_vs, p_de, p_blank, p_ls, p_fs, p_fv;
  logic [3:0] p_x, p_fx;
  logic [2:0] p_y, p_fy;
  logic d_pix_en, d_hs, d_vs, d_de, d_blank, d_ls, d_fs, d_fv;
  logic [3:0] d_x, d_fx;
  logic [2:0] d_y, d_fy;

  int checks = 0, errors = 0, e_cnt = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2), .LOOKAHEAD(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pix_en(pix_en), .hs(hs), .vs(vs), .de(de), .blank(blank),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
    .fetch_valid(fetch_valid), .fetch_x(fetch_x), .fetch_y(fetch_y)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(2), .LOOKAHEAD(3)
  ) dut_pol (
    .clk(clk), .rst(rst), .en(en), .pix_en(p_pix_en), .hs(p_hs), .vs(p_vs), .de(p_de), .blank(p_blank),
    .x(p_x), .y(p_y), .line_start(p_ls), .frame_start(p_fs),
    .fetch_valid(p_fv), .fetch_x(p_fx), .fetch_y(p_fy)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(1), .LOOKAHEAD(3)
  ) dut_d1 (
    .clk(clk), .rst(rst), .en(en), .pix_en(d_pix_en), .hs(d_hs), .vs(d_vs), .de(d_de), .blank(d_blank),
    .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs),
    .fetch_valid(d_fv), .fetch_x(d_fx), .fetch_y(d_fy)
  );

  // Scan position after e enabled edges; pre-roll position is FR-1.
  function automatic int pos_of(input int e, input int dv);
    return (e / dv + FR - 1) % FR;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      if (en && !rst) e_cnt++;
      #1;
    end
  endtask

  task automatic goto_pos(input int target);
    int n;
    n = 0;
    while (!(pos_of(e_cnt, 2) == target && (e_cnt % 2) == 0) && n < 300) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL goto_%0d: position not reached after %0d clk", target, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    tick(3);
    checks++;
    if ({de, blank, hs, vs, line_start, frame_start, fetch_valid, pix_en} !== 8'b0111_0000) begin
      errors++;
      $display("FAIL reset_flags: got %b exp 01110000",
               {de, blank, hs, vs, line_start, frame_start, fetch_valid, pix_en});
    end
    checks++;
    if ({x, y, fetch_x, fetch_y} !== 14'd0) begin
      errors++;
      $display("FAIL reset_coords: got %h exp 0", {x, y, fetch_x, fetch_y});
    end
    checks++;
    if ({p_hs, p_vs} !== 2'b01) begin
      errors++;
      $display("FAIL reset_pol: got %b exp 01", {p_hs, p_vs});
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b1; e_cnt = 0;
  endtask

  task automatic test_first_strobe();
    tick(1);
    checks++;
    if ({pix_en, de, frame_start, line_start} !== 4'b1000) begin
      errors++;
      $display("FAIL first_div: got %b exp 1000", {pix_en, de, frame_start, line_start});
    end
    checks++;
    if ({d_pix_en, d_de, d_fs, d_ls, d_x, d_y} !== {4'b1111, 4'd0, 3'd0}) begin
      errors++;
      $display("FAIL first_d1: got %h exp %h", {d_pix_en, d_de, d_fs, d_ls, d_x, d_y}, {4'b1111, 7'd0});
    end
    tick(1);
    checks++;
    if ({pix_en, de, line_start, frame_start, fetch_valid} !== 5'b01111) begin
      errors++;
      $display("FAIL first_strobe: got %b exp 01111", {pix_en, de, line_start, frame_start, fetch_valid});
    end
    checks++;
    if ({x, y, fetch_x, fetch_y} !== {4'd0, 3'd0, 4'd3, 3'd0}) begin
      errors++;
      $display("FAIL first_coords: got %h exp %h", {x, y, fetch_x, fetch_y}, {4'd0, 3'd0, 4'd3, 3'd0});
    end
  endtask

  task automatic test_frame_sweep();
    int p, h, v, fp, fh, fv, bad, pbad, n_fs, n_ls, n_pix, n_hlo, n_vlo, n_phi, n_dfs, gap_bad, last_ls;
    logic ede, ehs, evs, efv, eodd;
    logic [7:0] ef, af, bad_ef, bad_af;
    logic [13:0] exy, axy, bad_exy, bad_axy;
    bad = 0; pbad = 0; n_fs = 0; n_ls = 0; n_pix = 0; n_hlo = 0; n_vlo = 0; n_phi = 0;
    n_dfs = 0; gap_bad = 0; last_ls = -1;
    bad_ef = '0; bad_af = '0; bad_exy = '0; bad_axy = '0;
    for (int i = 0; i < 224; i++) begin
      tick(1);
      p = pos_of(e_cnt, 2); h = p % HT; v = p / HT;
      fp = (p + LA) % FR; fh = fp % HT; fv = fp / HT;
      eodd = (e_cnt % 2) == 1;
      ede = (h < HA) && (v < VA);
      ehs = !((h >= 10) && (h < 12));
      evs = (v != 5);
      efv = (fh < HA) && (fv < VA);
      ef  = {ede, !ede, ehs, evs, !eodd && (h == 0), !eodd && (p == 0), efv, eodd};
      af  = {de, blank, hs, vs, line_start, frame_start, fetch_valid, pix_en};
      exy = {ede ? 4'(h) : 4'd0, ede ? 3'(v) : 3'd0, efv ? 4'(fh) : 4'd0, efv ? 3'(fv) : 3'd0};
      axy = {x, y, fetch_x, fetch_y};
      if (af !== ef || axy !== exy) begin
        if (bad == 0) begin bad_ef = ef; bad_af = af; bad_exy = exy; bad_axy = axy; end
        bad++;
      end
      if (p_hs !== !ehs || p_vs !== evs) pbad++;
      if (frame_start === 1'b1) n_fs++;
      if (pix_en === 1'b1) n_pix++;
      if (hs === 1'b0) n_hlo++;
      if (vs === 1'b0) n_vlo++;
      if (p_hs === 1'b1) n_phi++;
      if (d_fs === 1'b1) n_dfs++;
      if (line_start === 1'b1) begin
        if (last_ls >= 0 && (i - last_ls) != 28) gap_bad++;
        last_ls = i;
        n_ls++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sweep_outputs: %0d bad clk, first got %b/%h exp %b/%h", bad, bad_af, bad_axy, bad_ef, bad_exy);
    end
    checks++;
    if (pbad != 0) begin errors++; $display("FAIL sweep_pol: got %0d bad clk exp 0", pbad); end
    checks++;
    if (n_fs != 1) begin errors++; $display("FAIL frame_start_count: got %0d exp 1", n_fs); end
    checks++;
    if (n_ls != 8) begin errors++; $display("FAIL line_start_count: got %0d exp 8", n_ls); end
    checks++;
    if (gap_bad != 0) begin errors++; $display("FAIL line_gap: got %0d bad gaps exp 0", gap_bad); end
    checks++;
    if (n_pix != 112) begin errors++; $display("FAIL pix_en_count: got %0d exp 112", n_pix); end
    checks++;
    if (n_hlo != 32) begin errors++; $display("FAIL hs_low_clk: got %0d exp 32", n_hlo); end
    checks++;
    if (n_vlo != 28) begin errors++; $display("FAIL vs_low_clk: got %0d exp 28", n_vlo); end
    checks++;
    if (n_phi != 32) begin errors++; $display("FAIL hs_pol_high_clk: got %0d exp 32", n_phi); end
    checks++;
    if (n_dfs != 2) begin errors++; $display("FAIL d1_frame_count: got %0d exp 2", n_dfs); end
  endtask

  task automatic test_fetch();
    goto_pos(0);
    checks++;
    if ({fetch_valid, fetch_x, fetch_y} !== {1'b1, 4'd3, 3'd0}) begin
      errors++;
      $display("FAIL fetch_0_0: got %h exp %h", {fetch_valid, fetch_x, fetch_y}, {1'b1, 4'd3, 3'd0});
    end
    goto_pos(47);
    checks++;
    if ({de, x, y, fetch_valid, fetch_x, fetch_y} !== {1'b1, 4'd5, 3'd3, 1'b0, 4'd0, 3'd0}) begin
      errors++;
      $display("FAIL fetch_5_3: got %h exp %h", {de, x, y, fetch_valid, fetch_x, fetch_y},
               {1'b1, 4'd5, 3'd3, 1'b0, 4'd0, 3'd0});
    end
    goto_pos(110);
    checks++;
    if ({de, x, y, fetch_valid, fetch_x, fetch_y} !== {1'b0, 4'd0, 3'd0, 1'b1, 4'd1, 3'd0}) begin
      errors++;
      $display("FAIL fetch_12_7: got %h exp %h", {de, x, y, fetch_valid, fetch_x, fetch_y},
               {1'b0, 4'd0, 3'd0, 1'b1, 4'd1, 3'd0});
    end
  endtask

  task automatic test_freeze();
    int bad;
    bad = 0;
    goto_pos(18);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if ({pix_en, de, hs, vs, line_start, frame_start, fetch_valid} !== 7'b0111001 ||
          {x, y, fetch_x, fetch_y} !== {4'd4, 3'd1, 4'd7, 3'd1}) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL freeze_hold: got %0d bad clk exp 0", bad); end
    en = 1'b1;
    tick(1);
    checks++;
    if ({pix_en, x} !== {1'b1, 4'd4}) begin
      errors++;
      $display("FAIL resume_div: got %h exp %h", {pix_en, x}, {1'b1, 4'd4});
    end
    tick(1);
    checks++;
    if ({pix_en, de, x, y} !== {1'b0, 1'b1, 4'd5, 3'd1}) begin
      errors++;
      $display("FAIL resume_x: got %h exp %h", {pix_en, de, x, y}, {1'b0, 1'b1, 4'd5, 3'd1});
    end
  endtask

  task automatic test_div1();
    int bad, p, h, v;
    logic ede;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      p = pos_of(e_cnt, 1); h = p % HT; v = p / HT;
      ede = (h < HA) && (v < VA);
      if ({d_pix_en, d_de, d_ls} !== {1'b1, ede, (h == 0)} ||
          {d_x, d_y} !== {ede ? 4'(h) : 4'd0, ede ? 3'(v) : 3'd0}) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL div1_stream: got %0d bad clk exp 0", bad); end
  endtask

  task automatic test_mid_reset();
    tick(7);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({de, blank, hs, vs, line_start, frame_start, fetch_valid, pix_en} !== 8'b0111_0000 ||
        {x, y, fetch_x, fetch_y} !== 14'd0) begin
      errors++;
      $display("FAIL midrst_main: got %b/%h exp 01110000/0",
               {de, blank, hs, vs, line_start, frame_start, fetch_valid, pix_en}, {x, y, fetch_x, fetch_y});
    end
    checks++;
    if ({p_hs, p_vs, d_de, d_hs, d_ls, d_fs, d_fv, d_x, d_y} !== {2'b01, 5'b01000, 7'd0}) begin
      errors++;
      $display("FAIL midrst_variants: got %h exp %h", {p_hs, p_vs, d_de, d_hs, d_ls, d_fs, d_fv, d_x, d_y},
               {2'b01, 5'b01000, 7'd0});
    end
    #1;
    @(negedge clk);
    rst = 1'b0; e_cnt = 0;
    tick(1);
    checks++;
    if ({pix_en, de, frame_start, d_fs, d_ls, d_de, d_x} !== {6'b100111, 4'd0}) begin
      errors++;
      $display("FAIL midrst_first_div: got %h exp %h", {pix_en, de, frame_start, d_fs, d_ls, d_de, d_x},
               {6'b100111, 4'd0});
    end
    tick(1);
    checks++;
    if ({de, line_start, frame_start, x, y, fetch_valid, fetch_x, fetch_y} !==
        {3'b111, 4'd0, 3'd0, 1'b1, 4'd3, 3'd0}) begin
      errors++;
      $display("FAIL midrst_strobe: got %h exp %h", {de, line_start, frame_start, x, y, fetch_valid, fetch_x, fetch_y},
               {3'b111, 4'd0, 3'd0, 1'b1, 4'd3, 3'd0});
    end
  endtask

  initial begin
    test_reset();
    test_first_strobe();
    test_frame_sweep();
    test_fetch();
    test_freeze();
    test_div1();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
